// File: rtl/snake_ladder_turn_ctrl.sv
// Two-player snake/ladder turn sequencer: takes dice rolls, publishes target squares,
// waits for the piece animation to settle, applies one jump, detects the winner.
module snake_ladder_turn_ctrl #(
  parameter int GOAL_POS   = 40,
  parameter int SETTLE_CYC = 2_500_000
) (
  input  logic       iClk,
  input  logic       iRst,
  input  logic       iNew_Game,
  input  logic       iRoll_Valid,
  input  logic [2:0] iRoll_Val,
  output logic       oRoll_Ready,
  input  logic [5:0] iP1_Anim_Pos,
  input  logic [5:0] iP2_Anim_Pos,
  output logic [5:0] oP1_Pos,
  output logic [5:0] oP2_Pos,
  output logic       oTurn,
  output logic       oBusy,
  output logic       oWinner_Valid,
  output logic       oWinner
);

  localparam int            CW        = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC);
  localparam logic [6:0]    GOAL7     = 7'(GOAL_POS);
  localparam logic [5:0]    GOAL6     = 6'(GOAL_POS);

  typedef enum logic [2:0] {
    S_WAIT_ROLL,
    S_WAIT_LAND,
    S_JUMP,
    S_WAIT_JUMP,
    S_CHECK_WIN,
    S_NEXT_TURN,
    S_GAME_OVER
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [5:0]    r_p1_pos, r_p2_pos;
  logic          r_turn, r_winner, r_armed;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_turn_nxt, w_winner_nxt, w_pub, w_xfer, w_jump_hit;
  logic [5:0]    w_pos, w_anim, w_new_pos, w_jump_dst, w_p1_nxt, w_p2_nxt;
  logic [6:0]    w_sum;

  assign w_pos  = r_turn ? r_p2_pos : r_p1_pos;
  assign w_anim = r_turn ? iP2_Anim_Pos : iP1_Anim_Pos;
  assign w_sum  = {1'b0, w_pos} + {4'b0, iRoll_Val};
  assign w_xfer = iRoll_Valid & oRoll_Ready;

  always_comb begin
    w_jump_hit = 1'b1;
    w_jump_dst = w_pos;
    case (w_pos)
      6'd3:    w_jump_dst = 6'd10;
      6'd8:    w_jump_dst = 6'd17;
      6'd23:   w_jump_dst = 6'd30;
      6'd11:   w_jump_dst = 6'd0;
      6'd26:   w_jump_dst = 6'd14;
      6'd35:   w_jump_dst = 6'd32;
      default: w_jump_hit = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_turn_nxt   = r_turn;
    w_winner_nxt = r_winner;
    w_cnt_nxt    = r_cnt;
    w_pub        = 1'b0;
    w_new_pos    = w_pos;
    case (r_state)
      S_WAIT_ROLL: begin
        if (w_xfer && iRoll_Val != 3'd0 && iRoll_Val != 3'd7) begin
          if (w_sum > GOAL7) begin
            w_state_nxt = S_NEXT_TURN;
          end else begin
            w_pub       = 1'b1;
            w_new_pos   = w_sum[5:0];
            w_cnt_nxt   = SETTLE_LD;
            w_state_nxt = S_WAIT_LAND;
          end
        end
      end
      // Settle timer restarts whenever the piece is not on its target square.
      S_WAIT_LAND, S_WAIT_JUMP: begin
        if (w_anim != w_pos) begin
          w_cnt_nxt = SETTLE_LD;
        end else if (r_cnt == '0) begin
          w_state_nxt = (r_state == S_WAIT_LAND) ? S_JUMP : S_CHECK_WIN;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_JUMP: begin
        if (w_jump_hit) begin
          w_pub       = 1'b1;
          w_new_pos   = w_jump_dst;
          w_cnt_nxt   = SETTLE_LD;
          w_state_nxt = S_WAIT_JUMP;
        end else begin
          w_state_nxt = S_CHECK_WIN;
        end
      end
      S_CHECK_WIN: begin
        if (w_pos == GOAL6) begin
          w_winner_nxt = r_turn;
          w_state_nxt  = S_GAME_OVER;
        end else begin
          w_state_nxt = S_NEXT_TURN;
        end
      end
      S_NEXT_TURN: begin
        w_turn_nxt  = ~r_turn;
        w_state_nxt = S_WAIT_ROLL;
      end
      S_GAME_OVER: w_state_nxt = S_GAME_OVER;
      default:     w_state_nxt = S_WAIT_ROLL;
    endcase
  end

  assign w_p1_nxt = (w_pub && !r_turn) ? w_new_pos : r_p1_pos;
  assign w_p2_nxt = (w_pub &&  r_turn) ? w_new_pos : r_p2_pos;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_state <= S_WAIT_ROLL;
    end else if (iNew_Game) begin
      r_state <= S_WAIT_ROLL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_armed keeps oRoll_Ready low for the first cycle after reset or a new game.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      r_p1_pos <= '0;
      r_p2_pos <= '0;
      r_turn   <= 1'b0;
      r_winner <= 1'b0;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
    end else if (iNew_Game) begin
      r_p1_pos <= '0;
      r_p2_pos <= '0;
      r_turn   <= 1'b0;
      r_winner <= 1'b0;
      r_cnt    <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_p1_pos <= w_p1_nxt;
      r_p2_pos <= w_p2_nxt;
      r_turn   <= w_turn_nxt;
      r_winner <= w_winner_nxt;
      r_cnt    <= w_cnt_nxt;
      r_armed  <= 1'b1;
    end
  end

  assign oRoll_Ready   = r_armed && (r_state == S_WAIT_ROLL);
  assign oBusy         = (r_state != S_WAIT_ROLL) && (r_state != S_GAME_OVER);
  assign oWinner_Valid = (r_state == S_GAME_OVER);
  assign oWinner       = r_winner;
  assign oP1_Pos       = r_p1_pos;
  assign oP2_Pos       = r_p2_pos;
  assign oTurn         = r_turn;

endmodule

// File: tb/tb_snake_ladder_turn_ctrl.sv
// Directed bench for snake_ladder_turn_ctrl: scripted game from a vector table plus
// hand-written reset, new-game and ignored-roll sequences.
module tb_snake_ladder_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       new_game = 1'b0;
  logic       roll_valid = 1'b0;
  logic [2:0] roll_val = 3'd0;
  logic       roll_ready;
  logic [5:0] p1_anim, p2_anim, p1_pos, p2_pos;
  logic       turn, busy, win_valid, winner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snake_ladder_turn_ctrl #(.GOAL_POS(40), .SETTLE_CYC(4)) dut (
    .iClk(clk), .iRst(rst), .iNew_Game(new_game),
    .iRoll_Valid(roll_valid), .iRoll_Val(roll_val), .oRoll_Ready(roll_ready),
    .iP1_Anim_Pos(p1_anim), .iP2_Anim_Pos(p2_anim),
    .oP1_Pos(p1_pos), .oP2_Pos(p2_pos), .oTurn(turn), .oBusy(busy),
    .oWinner_Valid(win_valid), .oWinner(winner)
  );

  // Motion controller model: reported square trails the published target by 10 cycles.
  logic [5:0] p1_pipe [10];
  logic [5:0] p2_pipe [10];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 10; i++) begin
        p1_pipe[i] <= 6'd0;
        p2_pipe[i] <= 6'd0;
      end
    end else begin
      for (int i = 9; i > 0; i--) begin
        p1_pipe[i] <= p1_pipe[i-1];
        p2_pipe[i] <= p2_pipe[i-1];
      end
      p1_pipe[0] <= p1_pos;
      p2_pipe[0] <= p2_pos;
    end
  end
  assign p1_anim = p1_pipe[9];
  assign p2_anim = p2_pipe[9];

  // kind: 0 = normal move, 1 = discarded roll (0/7), 2 = overshoot
  typedef struct {
    logic [2:0] roll;
    logic [1:0] kind;
    logic [5:0] pub;
    logic [5:0] p1;
    logic [5:0] p2;
    logic       turn;
    logic       winv;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!roll_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(roll_ready), 1);
  endtask

  logic       act_turn;
  logic [5:0] other0, pub;
  int         busy_cyc, n;
  bit         other_moved;

  initial begin
    vecs[0]  = '{3'd3, 2'd0, 6'd3,  6'd10, 6'd0,  1'b1, 1'b0};
    vecs[1]  = '{3'd5, 2'd0, 6'd5,  6'd10, 6'd5,  1'b0, 1'b0};
    vecs[2]  = '{3'd6, 2'd0, 6'd16, 6'd16, 6'd5,  1'b1, 1'b0};
    vecs[3]  = '{3'd6, 2'd0, 6'd11, 6'd16, 6'd0,  1'b0, 1'b0};
    vecs[4]  = '{3'd6, 2'd0, 6'd22, 6'd22, 6'd0,  1'b1, 1'b0};
    vecs[5]  = '{3'd6, 2'd0, 6'd6,  6'd22, 6'd6,  1'b0, 1'b0};
    vecs[6]  = '{3'd6, 2'd0, 6'd28, 6'd28, 6'd6,  1'b1, 1'b0};
    vecs[7]  = '{3'd6, 2'd0, 6'd12, 6'd28, 6'd12, 1'b0, 1'b0};
    vecs[8]  = '{3'd6, 2'd0, 6'd34, 6'd34, 6'd12, 1'b1, 1'b0};
    vecs[9]  = '{3'd6, 2'd0, 6'd18, 6'd34, 6'd18, 1'b0, 1'b0};
    vecs[10] = '{3'd3, 2'd0, 6'd37, 6'd37, 6'd18, 1'b1, 1'b0};
    vecs[11] = '{3'd4, 2'd0, 6'd22, 6'd37, 6'd22, 1'b0, 1'b0};
    vecs[12] = '{3'd4, 2'd2, 6'd37, 6'd37, 6'd22, 1'b1, 1'b0};
    vecs[13] = '{3'd6, 2'd0, 6'd28, 6'd37, 6'd28, 1'b0, 1'b0};
    vecs[14] = '{3'd0, 2'd1, 6'd37, 6'd37, 6'd28, 1'b0, 1'b0};
    vecs[15] = '{3'd7, 2'd1, 6'd37, 6'd37, 6'd28, 1'b0, 1'b0};
    vecs[16] = '{3'd5, 2'd2, 6'd37, 6'd37, 6'd28, 1'b1, 1'b0};
    vecs[17] = '{3'd6, 2'd0, 6'd34, 6'd37, 6'd34, 1'b0, 1'b0};
    vecs[18] = '{3'd1, 2'd0, 6'd38, 6'd38, 6'd34, 1'b1, 1'b0};
    vecs[19] = '{3'd6, 2'd0, 6'd40, 6'd38, 6'd40, 1'b1, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(roll_ready), 0);
    chk("rst_p1", 32'(p1_pos), 0);
    chk("rst_p2", 32'(p2_pos), 0);
    chk("rst_turn", 32'(turn), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_winv", 32'(win_valid), 0);
    rst = 1'b0;
    #1 chk("rel_ready_low", 32'(roll_ready), 0);
    @(negedge clk);
    chk("rel_ready_high", 32'(roll_ready), 1);

    // Scripted game
    for (int v = 0; v < NV; v++) begin
      wait_ready();
      act_turn = turn;
      other0   = act_turn ? p1_pos : p2_pos;
      roll_valid = 1'b1;
      roll_val   = vecs[v].roll;
      @(negedge clk);
      roll_valid = 1'b0;
      pub = act_turn ? p2_pos : p1_pos;
      if (vecs[v].kind == 2'd1) begin
        chk("discard_ready", 32'(roll_ready), 1);
      end else begin
        chk("first_publish", 32'(pub), 32'(vecs[v].pub));
        chk("busy_after_roll", 32'(busy), 1);
      end
      busy_cyc = 0;
      other_moved = 1'b0;
      while (!roll_ready && !win_valid && busy_cyc < 400) begin
        if ((act_turn ? p1_pos : p2_pos) != other0) other_moved = 1'b1;
        busy_cyc++;
        @(negedge clk);
      end
      if ((act_turn ? p1_pos : p2_pos) != other0) other_moved = 1'b1;
      chk("move_timeout", 32'(busy_cyc < 400), 1);
      if (vecs[v].kind == 2'd2) chk("overshoot_cycles", 32'(busy_cyc), 1);
      if (vecs[v].kind == 2'd0) chk("entered_wait_land", 32'(busy_cyc > 10), 1);
      chk("other_steady", 32'(other_moved), 0);
      chk("p1_pos", 32'(p1_pos), 32'(vecs[v].p1));
      chk("p2_pos", 32'(p2_pos), 32'(vecs[v].p2));
      chk("turn", 32'(turn), 32'(vecs[v].turn));
      chk("winner_valid", 32'(win_valid), 32'(vecs[v].winv));
    end
    chk("winner", 32'(winner), 1);
    chk("over_ready", 32'(roll_ready), 0);

    // Rolls offered in GAME_OVER are ignored
    roll_valid = 1'b1;
    roll_val   = 3'd2;
    repeat (5) @(negedge clk);
    roll_valid = 1'b0;
    chk("over_ignore_ready", 32'(roll_ready), 0);
    chk("over_ignore_p1", 32'(p1_pos), 38);
    chk("over_ignore_p2", 32'(p2_pos), 40);
    chk("over_ignore_winv", 32'(win_valid), 1);
    chk("over_ignore_busy", 32'(busy), 0);

    // New game from GAME_OVER
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    chk("ng_p1", 32'(p1_pos), 0);
    chk("ng_p2", 32'(p2_pos), 0);
    chk("ng_turn", 32'(turn), 0);
    chk("ng_winv", 32'(win_valid), 0);
    chk("ng_winner", 32'(winner), 0);
    chk("ng_ready_low", 32'(roll_ready), 0);
    @(negedge clk);
    chk("ng_ready_high", 32'(roll_ready), 1);

    // iRoll_Valid held while busy must not be buffered
    wait_ready();
    roll_valid = 1'b1;
    roll_val   = 3'd2;
    @(negedge clk);
    n = 0;
    while (!roll_ready && n < 400) begin
      roll_valid = 1'b1;
      roll_val   = 3'd5;
      @(negedge clk);
      n++;
    end
    roll_valid = 1'b0;
    chk("busy_ignore_timeout", 32'(n < 400), 1);
    chk("busy_ignore_p1", 32'(p1_pos), 2);
    chk("busy_ignore_p2", 32'(p2_pos), 0);
    chk("busy_ignore_turn", 32'(turn), 1);

    // Asynchronous reset while the ladder jump is animating
    wait_ready();
    roll_valid = 1'b1;
    roll_val   = 3'd3;
    @(negedge clk);
    roll_valid = 1'b0;
    n = 0;
    while (p2_pos != 6'd10 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("jump_published", 32'(p2_pos), 10);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_p1", 32'(p1_pos), 0);
    chk("arst_p2", 32'(p2_pos), 0);
    chk("arst_turn", 32'(turn), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(roll_ready), 0);
    chk("arst_winv", 32'(win_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_ready_after", 32'(roll_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
